vga_sync_monitor: RTL

Receive-side counterpart of the VGA timing generator. Samples incoming horizontal and vertical sync pulses, measures line length in clocks and frame length in lines, and recovers the pixel coordinate and active-video flag. Runs a lock state machine that declares the timing stable and flags deviations. Used for loopback checking of the generator and for slaving downstream pixel logic to an external sync source.

---
 rtl/vga_sync_monitor_if.sv | 27 ++
 rtl/vga_sync_monitor.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor_if.sv
`default_nettype none
// ============================================================================
// vga_sync_monitor_if : sync inputs and recovered timing outputs of the monitor
// Rev 1.0
// ============================================================================
interface vga_sync_monitor_if;
  logic        hs_in;
  logic        vs_in;
  logic [10:0] h_pos;
  logic [10:0] v_pos;
  logic        pixel_valid;
  logic [12:0] line_len;
  logic [10:0] frame_lines;
  logic        locked;
  logic        timing_err;

  modport master (
    output hs_in, vs_in,
    input  h_pos, v_pos, pixel_valid, line_len, frame_lines, locked, timing_err
  );

  modport slave (
    input  hs_in, vs_in,
    output h_pos, v_pos, pixel_valid, line_len, frame_lines, locked, timing_err
  );
endinterface
`default_nettype wire

// File: rtl/vga_sync_monitor.sv
`default_nettype none
// ============================================================================
// vga_sync_monitor : measures incoming HS/VS timing, recovers pixel position, lock FSM
// Rev 1.0
// ============================================================================
module vga_sync_monitor #(
  parameter int H_BACK      = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_BACK      = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst,
  vga_sync_monitor_if.slave  mon
);

  localparam logic [12:0] C_HCNT_MAX  = 13'h1FFF;
  localparam logic [10:0] C_VLINE_MAX = 11'h7FF;
  localparam logic [12:0] C_H_LO      = 13'(H_BACK);
  localparam logic [12:0] C_H_HI      = 13'(H_BACK + H_ACTIVE);
  localparam logic [10:0] C_V_LO      = 11'(V_BACK);
  localparam logic [10:0] C_V_HI      = 11'(V_BACK + V_ACTIVE);
  localparam logic [3:0]  C_LOCK      = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        hs_q, vs_q;
  logic [12:0] hcnt_q, hcnt_d, len_q, len_d;
  logic [10:0] vline_q, vline_d, fl_q, fl_d;
  logic [3:0]  good_q, good_d;
  logic        bad_q, bad_d, err_q, err_d;

  logic        hs_fall, vs_fall, line_mis, frame_mis, h_act, v_act;
  logic [12:0] hcnt_inc;
  logic [10:0] vline_inc;
  logic [3:0]  good_inc;

  assign hs_fall   = hs_q & ~mon.hs_in;
  assign vs_fall   = vs_q & ~mon.vs_in;
  assign hcnt_inc  = hcnt_q + 13'd1;
  assign vline_inc = vline_q + 11'd1;
  assign good_inc  = good_q + 4'd1;
  assign line_mis  = hs_fall && (hcnt_inc != len_q);
  assign frame_mis = vs_fall && (vline_inc != fl_q);

  always_comb begin
    hcnt_d  = hs_fall ? 13'd0 : ((hcnt_q == C_HCNT_MAX) ? hcnt_q : hcnt_inc);
    vline_d = vline_q;
    if (vs_fall)
      vline_d = 11'd0;
    else if (hs_fall && (vline_q != C_VLINE_MAX))
      vline_d = vline_inc;
    len_d = hs_fall ? hcnt_inc : len_q;
    fl_d  = vs_fall ? vline_inc : fl_q;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = TRACK;
          good_d  = 4'd0;
          bad_d   = line_mis;
        end
      end
      TRACK: begin
        if (line_mis)
          bad_d = 1'b1;
        // A mismatch on the line closing the frame is charged to the next frame.
        if (vs_fall) begin
          bad_d = line_mis;
          if (!bad_q && !frame_mis) begin
            good_d = good_inc;
            if (good_inc == C_LOCK)
              state_d = LOCKED;
          end else begin
            good_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (line_mis || frame_mis) begin
          err_d   = 1'b1;
          state_d = TRACK;
          good_d  = 4'd0;
          bad_d   = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
    // Loss of HS entirely is a silent drop back to acquisition, not a deviation.
    if ((state_q != SEARCH) && (hcnt_q == C_HCNT_MAX)) begin
      state_d = SEARCH;
      good_d  = 4'd0;
      bad_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      hcnt_q  <= '0;
      vline_q <= '0;
      len_q   <= '0;
      fl_q    <= '0;
      good_q  <= '0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      state_q <= SEARCH;
    end else begin
      hs_q    <= mon.hs_in;
      vs_q    <= mon.vs_in;
      hcnt_q  <= hcnt_d;
      vline_q <= vline_d;
      len_q   <= len_d;
      fl_q    <= fl_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  assign h_act = (hcnt_q >= C_H_LO) && (hcnt_q < C_H_HI);
  assign v_act = (vline_q >= C_V_LO) && (vline_q < C_V_HI);

  assign mon.h_pos       = (h_act && v_act) ? 11'(hcnt_q - C_H_LO) : 11'd0;
  assign mon.v_pos       = (h_act && v_act) ? (vline_q - C_V_LO) : 11'd0;
  assign mon.locked      = (state_q == LOCKED);
  assign mon.pixel_valid = h_act && v_act && (state_q == LOCKED);
  assign mon.line_len    = len_q;
  assign mon.frame_lines = fl_q;
  assign mon.timing_err  = err_q;

endmodule
`default_nettype wire
